// File: rtl/clk_enable_gen.sv
// Clock-enable generator: NUM_CLOCKS phase-aligned divided square waves and enable pulses from refclk,
// gated by a lock FSM. Define CLK_ENABLE_GEN_PHASE_EN to add a per-channel start phase (PHASE_INIT, cfg_phase).
module clk_enable_gen #(
   parameter int unsigned                     NUM_CLOCKS  = 2,
   parameter int unsigned                     DIV_WIDTH   = 8,
   parameter logic [NUM_CLOCKS*DIV_WIDTH-1:0] DIV_INIT    = {8'd8, 8'd4},
`ifdef CLK_ENABLE_GEN_PHASE_EN
   parameter logic [NUM_CLOCKS*DIV_WIDTH-1:0] PHASE_INIT  = '0,
`endif
   parameter int unsigned                     LOCK_CYCLES = 16
) (
   input  logic                  refclk,
   input  logic                  rst_n,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [2:0]            cfg_sel,
   input  logic [DIV_WIDTH-1:0]  cfg_div,
`ifdef CLK_ENABLE_GEN_PHASE_EN
   input  logic [DIV_WIDTH-1:0]  cfg_phase,
`endif
   output logic                  cfg_err,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic [NUM_CLOCKS-1:0] outclk_en,
   output logic                  locked
);

   localparam int unsigned LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOCKING = 2'd1,
      ST_LOCKED  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
   logic             locked_q, locked_d;
   logic             cfg_err_q;
   logic             cfg_fire, cfg_bad, cfg_accept, cfg_reject;
   logic             chan_run;

   // A request is only seen while locked; a bad one is flagged and otherwise dropped.
   assign cfg_fire   = cfg_valid && locked_q;
   assign cfg_bad    = (cfg_div == '0) || (32'(cfg_sel) >= NUM_CLOCKS);
   assign cfg_accept = cfg_fire && !cfg_bad;
   assign cfg_reject = cfg_fire && cfg_bad;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // Lock sequencing: every accepted reconfiguration re-enters LOCKING for LOCK_CYCLES edges.
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         ST_IDLE: begin
            state_d    = ST_LOCKING;
            lock_cnt_d = '0;
         end
         ST_LOCKING: begin
            if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
               state_d = ST_LOCKED;
            end else begin
               lock_cnt_d = lock_cnt_q + LCW'(1);
            end
         end
         ST_LOCKED: begin
            if (cfg_accept) begin
               state_d    = ST_LOCKING;
               lock_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
         end
      endcase
   end

   assign locked_d = (state_d == ST_LOCKED);
   // Counters advance only across edges where locked is high both before and after.
   assign chan_run = locked_q && locked_d;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         locked_q  <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         locked_q  <= locked_d;
         cfg_err_q <= cfg_reject;
      end
   end

   assign locked    = locked_q;
   assign cfg_ready = locked_q;
   assign cfg_err   = cfg_err_q;

   for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
      localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_INIT[g*DIV_WIDTH +: DIV_WIDTH];
`ifdef CLK_ENABLE_GEN_PHASE_EN
      localparam logic [DIV_WIDTH-1:0] START_RST = PHASE_INIT[g*DIV_WIDTH +: DIV_WIDTH] % DIV_RST;
`else
      localparam logic [DIV_WIDTH-1:0] START_RST = '0;
`endif

      logic [DIV_WIDTH-1:0] div_q, div_d;
      logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
      logic [DIV_WIDTH-1:0] start_d;
      logic                 clk_q, clk_d;
      logic                 en_q, en_d;
      logic                 load;

      assign load = cfg_accept && (cfg_sel == 3'(g));

`ifdef CLK_ENABLE_GEN_PHASE_EN
      logic [DIV_WIDTH-1:0] start_q;

      always_ff @(posedge refclk or negedge rst_n) begin
         if (!rst_n) begin
            start_q <= START_RST;
         end else begin
            start_q <= start_d;
         end
      end
`endif

      always_comb begin
         div_d = div_q;
`ifdef CLK_ENABLE_GEN_PHASE_EN
         start_d = start_q;
         if (load) begin
            div_d   = cfg_div;
            start_d = cfg_phase % cfg_div;
         end
`else
         start_d = '0;
         if (load) begin
            div_d = cfg_div;
         end
`endif
         if (chan_run) begin
            cnt_d = (cnt_q == div_q - DIV_WIDTH'(1)) ? '0 : cnt_q + DIV_WIDTH'(1);
         end else begin
            cnt_d = start_d;
         end
         clk_d = chan_run && (cnt_q < (div_q >> 1));
         en_d  = chan_run && (cnt_q == div_q - DIV_WIDTH'(1));
      end

      always_ff @(posedge refclk or negedge rst_n) begin
         if (!rst_n) begin
            div_q <= DIV_RST;
            cnt_q <= START_RST;
            clk_q <= 1'b0;
            en_q  <= 1'b0;
         end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            clk_q <= clk_d;
            en_q  <= en_d;
         end
      end

      assign outclk[g]    = clk_q;
      assign outclk_en[g] = en_q;
   end

endmodule

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 SHALL have parameter NUM_CLOCKS, default 2: number of output channels, legal range 1..8.
REQ-002 SHALL have parameter DIV_WIDTH, default 8: width of each channel divide ratio.
REQ-003 SHALL have parameter DIV_INIT, default {8'd8, 8'd4}: packed per-channel reset divide ratios, channel 0 in the LSBs.
REQ-004 SHALL have parameter LOCK_CYCLES, default 16: refclk cycles from reset release or reconfiguration to locked.
REQ-005 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-006 SHALL have port refclk, input, 1: sole clock, all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port cfg_valid, input, 1: reconfiguration request.
REQ-009 SHALL have port cfg_ready, output, 1: request accepted when cfg_valid and cfg_ready are both high on a clock edge.
REQ-010 SHALL have port cfg_sel, input, 3: target channel index.
REQ-011 SHALL have port cfg_div, input, DIV_WIDTH: new divide ratio.
REQ-012 SHALL have port cfg_err, output, 1: one-cycle pulse for a rejected request.
REQ-013 SHALL have port outclk, output, NUM_CLOCKS: registered divided square waves.
REQ-014 SHALL have port outclk_en, output, NUM_CLOCKS: registered one-cycle clock-enable pulses.
REQ-015 SHALL have port locked, output, 1: all channels running at their configured ratio.

Function
REQ-016 SHALL give each channel i a counter cnt[i] that counts 0..div[i]-1 and wraps to 0.
REQ-017 SHALL drive outclk_en[i] high for exactly one cycle when cnt[i]==div[i]-1 and locked is high.
REQ-018 SHALL drive outclk[i] high while cnt[i] < div[i]/2 (integer division) and locked is high: even div gives 50% duty; odd div gives floor(div/2) cycles high; div=1 gives outclk held low and outclk_en held high.
REQ-019 SHALL hold outclk and outclk_en at 0 while locked is low, with counters held at their start value.
REQ-020 SHALL operate the lock FSM as IDLE -> LOCKING -> LOCKED: IDLE on reset; LOCKING on the first edge after reset release; LOCKED after LOCK_CYCLES edges in LOCKING; back to LOCKING on an accepted request.
REQ-021 SHALL drive locked = (state==LOCKED), registered, and cfg_ready = locked.
REQ-022 SHALL, on an accepted request, load div[cfg_sel]=cfg_div on the next edge and restart all channel counters together, keeping channels phase-aligned.
REQ-023 SHALL reject a request with cfg_div==0 or cfg_sel>=NUM_CLOCKS: pulse cfg_err for one cycle, change no state, and keep locked high.
REQ-024 SHALL ignore cfg_valid while cfg_ready is low; the requester holds the request until it is accepted.
REQ-025 SHALL make the first outclk_en pulse of channel i appear exactly div[i] cycles after locked rises.

Reset
REQ-026 SHALL, while rst_n is low: set outclk=0, outclk_en=0, locked=0, cfg_ready=0, cfg_err=0, state=IDLE, div[i]=DIV_INIT[i], and counters to their start value.
REQ-027 SHALL, on assertion of rst_n mid-operation, force the reset values immediately and discard any ratio written by a reconfiguration.

Configuration
REQ-028 SHALL, with CLK_ENABLE_GEN_PHASE_EN defined, provide parameter PHASE_INIT (packed, same layout as DIV_INIT) and input cfg_phase (DIV_WIDTH).
REQ-029 SHALL, with CLK_ENABLE_GEN_PHASE_EN defined, use phase[i] mod div[i] as the start value of channel i, with phase loaded together with the divide ratio on an accepted request.
REQ-030 SHALL, without CLK_ENABLE_GEN_PHASE_EN, omit PHASE_INIT and cfg_phase and use 0 as the start value of every channel.

Verification
REQ-031 SHALL verify: defaults, rst_n released at cycle 0 -> locked rises at cycle 16; ch0 outclk_en every 4 cycles, outclk 2 high/2 low; ch1 outclk_en every 8 cycles.
REQ-032 SHALL verify: while locked, request sel=1, div=5 -> locked low for 16 cycles; then ch1 outclk 2 high/3 low, outclk_en every 5 cycles; ch0 unchanged and realigned.
REQ-033 SHALL verify: request div=0, then a request with sel=7 -> one cfg_err pulse each, locked stays high, ratios unchanged.
REQ-034 SHALL verify: cfg_valid held from cycle 5 after reset release -> accepted only at cycle 16, when cfg_ready first goes high.
REQ-035 SHALL verify: rst_n pulsed low mid-run after ch1 was reconfigured to 5 -> all outputs 0 immediately; ch1 returns to ratio 8 after relock.
REQ-036 SHALL verify, with CLK_ENABLE_GEN_PHASE_EN: PHASE_INIT ch1=4, both ratios 8 -> ch1 outclk_en leads ch0 by 4 cycles.
